// File: rtl/key_action_scheduler.sv
// PS/2 byte-stream parser for the dinosaur game: turns make/break codes (with E0/F0
// prefixes) into jump/start pulses and a duck level, with prefix timeout and jump cooldown.
module key_action_scheduler #(
    parameter int unsigned CLOCK_FREQUENCY = 25000000,
    parameter int unsigned TIMEOUT_CYCLES  = 250000,
    parameter int unsigned COOLDOWN_CYCLES = 1250000,
    parameter logic [7:0]  JUMP_CODE       = 8'h29,
    parameter logic [7:0]  JUMP_EXT_CODE   = 8'h75,
    parameter logic [7:0]  DUCK_EXT_CODE   = 8'h72,
    parameter logic [7:0]  START_CODE      = 8'h5A
) (
    input  logic       Clock,
    input  logic       reset,
    input  logic [7:0] key_data,
    input  logic       key_valid,
    output logic       jump_pulse,
    output logic       duck,
    output logic       start_pulse,
    output logic [7:0] last_code
);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CD_W = $clog2(COOLDOWN_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

    state_t         state_q, state_d;
    logic [TO_W-1:0] to_q, to_d;
    logic [CD_W-1:0] cd_q, cd_d;
    logic           jump_held_q, jump_held_d;
    logic           duck_held_q, duck_held_d;
    logic           start_held_q, start_held_d;
    logic           jp_q, jp_d, sp_q, sp_d, duck_q, duck_d;
    logic [7:0]     last_q, last_d;

    logic done, is_ext, is_brk;
    logic hit_jump, hit_duck, hit_start;

    always_comb begin
        state_d = state_q;
        to_d    = to_q;
        done    = 1'b0;
        is_ext  = 1'b0;
        is_brk  = 1'b0;
        if (key_valid) begin
            // A byte always wins over a timeout expiring in the same cycle.
            to_d = '0;
            unique case (state_q)
                S_IDLE: begin
                    if (key_data == 8'hE0)      state_d = S_EXT;
                    else if (key_data == 8'hF0) state_d = S_BRK;
                    else                        done = 1'b1;
                end
                S_EXT: begin
                    if (key_data == 8'hF0)      state_d = S_EXT_BRK;
                    else if (key_data == 8'hE0) state_d = S_EXT;
                    else begin
                        done    = 1'b1;
                        is_ext  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_BRK, S_EXT_BRK: begin
                    state_d = S_IDLE;
                    if (key_data != 8'hE0 && key_data != 8'hF0) begin
                        done   = 1'b1;
                        is_brk = 1'b1;
                        is_ext = (state_q == S_EXT_BRK);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE) begin
            if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                state_d = S_IDLE;
                to_d    = '0;
            end else begin
                to_d = to_q + TO_W'(1);
            end
        end else begin
            to_d = '0;
        end

        hit_jump  = done & (is_ext ? (key_data == JUMP_EXT_CODE) : (key_data == JUMP_CODE));
        hit_duck  = done & is_ext & (key_data == DUCK_EXT_CODE);
        hit_start = done & ~is_ext & (key_data == START_CODE);

        jump_held_d  = hit_jump  ? ~is_brk : jump_held_q;
        duck_held_d  = hit_duck  ? ~is_brk : duck_held_q;
        start_held_d = hit_start ? ~is_brk : start_held_q;

        // Presses during cooldown still mark the key held, so they are dropped, not queued.
        jp_d = hit_jump & ~is_brk & ~jump_held_q & (cd_q == '0);
        sp_d = hit_start & ~is_brk & ~start_held_q;

        if (jp_d)             cd_d = CD_W'(COOLDOWN_CYCLES - 1);
        else if (cd_q != '0)  cd_d = cd_q - CD_W'(1);
        else                  cd_d = cd_q;

        duck_d = duck_held_d & ~jump_held_d;
        last_d = done ? key_data : last_q;
    end

    always_ff @(posedge Clock) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            to_q         <= '0;
            cd_q         <= '0;
            jump_held_q  <= 1'b0;
            duck_held_q  <= 1'b0;
            start_held_q <= 1'b0;
            jp_q         <= 1'b0;
            sp_q         <= 1'b0;
            duck_q       <= 1'b0;
            last_q       <= 8'h00;
        end else begin
            state_q      <= state_d;
            to_q         <= to_d;
            cd_q         <= cd_d;
            jump_held_q  <= jump_held_d;
            duck_held_q  <= duck_held_d;
            start_held_q <= start_held_d;
            jp_q         <= jp_d;
            sp_q         <= sp_d;
            duck_q       <= duck_d;
            last_q       <= last_d;
        end
    end

    assign jump_pulse  = jp_q;
    assign start_pulse = sp_q;
    assign duck        = duck_q;
    assign last_code   = last_q;
endmodule

// File: tb/tb_key_action_scheduler.sv
// Bench for key_action_scheduler: event-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized byte streams.
module tb_key_action_scheduler;
    localparam int TMO  = 20;
    localparam int COOL = 30;

    logic       Clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] key_data = 8'h00;
    logic       key_valid = 1'b0;
    logic       jump_pulse, duck, start_pulse;
    logic [7:0] last_code;

    key_action_scheduler #(
        .CLOCK_FREQUENCY(25000000), .TIMEOUT_CYCLES(TMO), .COOLDOWN_CYCLES(COOL),
        .JUMP_CODE(8'h29), .JUMP_EXT_CODE(8'h75), .DUCK_EXT_CODE(8'h72), .START_CODE(8'h5A)
    ) dut (
        .Clock(Clock), .reset(reset), .key_data(key_data), .key_valid(key_valid),
        .jump_pulse(jump_pulse), .duck(duck), .start_pulse(start_pulse), .last_code(last_code)
    );

    always #5 Clock = ~Clock;

    int vectors = 0;
    int miscompares = 0;
    int jp_cnt = 0;
    int sp_cnt = 0;

    // Reference model: key state as "pending prefix" flags plus event timestamps.
    int       cyc = 0;
    int       last_byte_cyc = 0;
    int       last_pulse_cyc = -1000000;
    bit       m_ext = 0, m_brk = 0;
    bit       jh = 0, dh = 0, sh = 0;
    logic [7:0] m_last = 8'h00;
    bit       e_jp = 0, e_sp = 0, e_duck = 0;
    bit       started = 0;

    always @(posedge Clock) begin
        cyc++;
        e_jp = 0;
        e_sp = 0;
        if (!reset) begin
            m_ext = 0; m_brk = 0; jh = 0; dh = 0; sh = 0;
            m_last = 8'h00; last_pulse_cyc = -1000000; e_duck = 0;
        end else if (key_valid) begin
            if ((m_ext || m_brk) && (cyc - last_byte_cyc > TMO)) begin
                m_ext = 0; m_brk = 0;
            end
            last_byte_cyc = cyc;
            if (!m_brk && key_data == 8'hE0) m_ext = 1;
            else if (!m_brk && key_data == 8'hF0) m_brk = 1;
            else if (m_brk && (key_data == 8'hE0 || key_data == 8'hF0)) begin
                m_ext = 0; m_brk = 0;
            end else begin
                m_last = key_data;
                if ((!m_ext && key_data == 8'h29) || (m_ext && key_data == 8'h75)) begin
                    if (!m_brk) begin
                        if (!jh && (cyc - last_pulse_cyc >= COOL)) begin
                            e_jp = 1;
                            last_pulse_cyc = cyc;
                        end
                        jh = 1;
                    end else jh = 0;
                end
                if (m_ext && key_data == 8'h72) dh = !m_brk;
                if (!m_ext && key_data == 8'h5A) begin
                    if (!m_brk && !sh) e_sp = 1;
                    sh = !m_brk;
                end
                m_ext = 0; m_brk = 0;
            end
            e_duck = dh && !jh;
        end
        started = 1;
    end

    always @(negedge Clock) begin
        if (started) begin
            vectors++;
            if (jump_pulse !== e_jp || start_pulse !== e_sp || duck !== e_duck || last_code !== m_last) begin
                miscompares++;
                $display("FAIL model t=%0t: jp %b/%b sp %b/%b duck %b/%b last %h/%h (got/exp)",
                         $time, jump_pulse, e_jp, start_pulse, e_sp, duck, e_duck, last_code, m_last);
            end
            jp_cnt += int'(jump_pulse === 1'b1);
            sp_cnt += int'(start_pulse === 1'b1);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int idle);
        key_data  = b;
        key_valid = 1'b1;
        @(negedge Clock);
        key_valid = 1'b0;
        repeat (idle) @(negedge Clock);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge Clock);
        reset = 1'b1;
        @(negedge Clock);
    endtask

    int j0, s0;
    logic [7:0] b;
    int r, idle;

    initial begin
        do_reset();
        chk("reset_jp", jump_pulse, 0);
        chk("reset_duck", duck, 0);
        chk("reset_last", last_code, 8'h00);

        // 1: single press and release
        j0 = jp_cnt;
        send(8'h29, 0);
        chk("t1_pulse", jump_pulse, 1);
        send(8'hF0, 0);
        send(8'h29, 3);
        chk("t1_count", jp_cnt - j0, 1);
        chk("t1_duck", duck, 0);
        chk("t1_last", last_code, 8'h29);

        // 2: typematic repeats, release, re-press after cooldown
        do_reset();
        j0 = jp_cnt;
        send(8'h29, 1); send(8'h29, 1); send(8'h29, 1);
        send(8'hF0, 0); send(8'h29, COOL + 2);
        send(8'h29, 3);
        chk("t2_count", jp_cnt - j0, 2);

        // 3: duck arbitration against jump
        do_reset();
        send(8'hE0, 0); send(8'h72, 0);
        chk("t3_duck_on", duck, 1);
        send(8'h29, 0);
        chk("t3_jump", jump_pulse, 1);
        chk("t3_duck_masked", duck, 0);
        send(8'hF0, 0); send(8'h29, 0);
        chk("t3_duck_resume", duck, 1);
        send(8'hE0, 0); send(8'hF0, 0); send(8'h72, 0);
        chk("t3_duck_off", duck, 0);

        // 4: prefix timeout, with the exact boundary on either side
        do_reset();
        send(8'hE0, TMO - 1); send(8'h72, 0);
        chk("t4_edge_kept", duck, 1);
        send(8'hE0, 0); send(8'hF0, 0); send(8'h72, 0);
        send(8'hE0, TMO); send(8'h72, 2);
        chk("t4_expired_duck", duck, 0);
        chk("t4_last", last_code, 8'h72);

        // 5: press inside cooldown is dropped; start pulses
        do_reset();
        j0 = jp_cnt; s0 = sp_cnt;
        send(8'h29, 0); send(8'hF0, 0); send(8'h29, 2); send(8'h29, 3);
        chk("t5_dropped", jp_cnt - j0, 1);
        send(8'h5A, 0);
        chk("t5_start", start_pulse, 1);
        send(8'h5A, 2);
        chk("t5_start_count", sp_cnt - s0, 1);

        // 6: reset in the middle of an E0 F0 prefix
        do_reset();
        send(8'hE0, 0); send(8'hF0, 0);
        reset = 1'b0; @(negedge Clock); reset = 1'b1;
        chk("t6_rst_last", last_code, 8'h00);
        send(8'h72, 1);
        chk("t6_duck", duck, 0);
        chk("t6_last", last_code, 8'h72);

        // Randomized streams: key codes, prefixes, junk, timeout and cooldown edge gaps.
        for (int i = 0; i < 700; i++) begin
            r = $urandom_range(0, 7);
            case (r)
                0: b = 8'h29;
                1: b = 8'h75;
                2: b = 8'h72;
                3: b = 8'h5A;
                4: b = 8'hE0;
                5, 7: b = 8'hF0;
                default: b = 8'($urandom_range(0, 255));
            endcase
            r = $urandom_range(0, 15);
            if (r == 0)      idle = $urandom_range(TMO - 2, TMO + 1);
            else if (r == 1) idle = $urandom_range(COOL - 3, COOL);
            else             idle = $urandom_range(0, 4);
            send(b, idle);
            if ($urandom_range(0, 59) == 0) begin
                reset = 1'b0; @(negedge Clock); reset = 1'b1;
            end
        end
        repeat (3) @(negedge Clock);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
